// File: rtl/itag_seq_ctl.sv
// rtl/itag_seq_ctl.sv - sequencer/arbiter sharing the itag_shell tag port between flush, fill and lookup
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   flush_req             pulse: invalidate the whole tag array
//   flush_busy/flush_done walk in progress / 1-cycle completion pulse
//   pwrdn_req             level: enter low-power mode when idle
//   fill_req/addr/tag/gnt tag write request and combinational grant
//   lk_req/addr/tag/gnt   lookup request and combinational grant
//   lk_rsp_vld/lk_hit     lookup result, one cycle after lk_gnt
//   tag_addr/in/vld/we    tag port towards itag_shell
//   tag_pwrdn             itag_shell power-down (1 = down)
//   itag_hit              itag_shell hit result
module itag_seq_ctl #(
    parameter int IDX_W = 9,
    parameter int TAG_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    input  logic             pwrdn_req,
    input  logic             fill_req,
    input  logic [IDX_W-1:0] fill_addr,
    input  logic [TAG_W-1:0] fill_tag,
    output logic             fill_gnt,
    input  logic             lk_req,
    input  logic [IDX_W-1:0] lk_addr,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_gnt,
    output logic             lk_rsp_vld,
    output logic             lk_hit,
    output logic [IDX_W-1:0] tag_addr,
    output logic [TAG_W-1:0] tag_in,
    output logic             tag_vld,
    output logic             tag_we,
    output logic             tag_pwrdn,
    input  logic             itag_hit
);

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             flush_pend;

    // Last values driven on the tag port, so idle cycles do not toggle it.
    logic [IDX_W-1:0] addr_q;
    logic [TAG_W-1:0] in_q;
    logic             vld_q;

    logic any_req;
    assign any_req = flush_req | fill_req | lk_req;

    assign flush_busy = (state == ST_FLUSH);
    // The array registers its enable, so WAKE already drives it low.
    assign tag_pwrdn  = (state == ST_SLEEP);
    assign lk_hit     = lk_rsp_vld & itag_hit;

    always_comb begin
        fill_gnt = 1'b0;
        lk_gnt   = 1'b0;
        tag_we   = 1'b0;
        tag_addr = addr_q;
        tag_in   = in_q;
        tag_vld  = vld_q;
        case (state)
            ST_FLUSH: begin
                tag_we   = 1'b1;
                tag_addr = idx;
                tag_in   = '0;
                tag_vld  = 1'b0;
            end
            ST_IDLE: begin
                // flush_req takes the cycle without a grant
                if (!flush_req) begin
                    if (fill_req) begin
                        fill_gnt = 1'b1;
                        tag_we   = 1'b1;
                        tag_addr = fill_addr;
                        tag_in   = fill_tag;
                        tag_vld  = 1'b1;
                    end else if (lk_req) begin
                        lk_gnt   = 1'b1;
                        tag_addr = lk_addr;
                        tag_in   = lk_tag;
                        tag_vld  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            idx        <= '0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            lk_rsp_vld <= 1'b0;
            addr_q     <= '0;
            in_q       <= '0;
            vld_q      <= 1'b0;
        end else begin
            addr_q     <= tag_addr;
            in_q       <= tag_in;
            vld_q      <= tag_vld;
            lk_rsp_vld <= lk_gnt;
            flush_done <= 1'b0;
            case (state)
                ST_FLUSH: begin
                    if (flush_req) begin
                        idx <= '0;
                    end else if (idx == IDX_LAST) begin
                        idx        <= '0;
                        state      <= ST_IDLE;
                        flush_done <= 1'b1;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        idx   <= '0;
                        state <= ST_FLUSH;
                    end else if (!fill_req && !lk_req && pwrdn_req) begin
                        state <= ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    if (flush_req) begin
                        flush_pend <= 1'b1;
                    end
                    if (!pwrdn_req || any_req) begin
                        state <= ST_WAKE;
                    end
                end
                default: begin
                    // WAKE lasts one cycle; a flush_req seen here is honoured too
                    if (flush_pend || flush_req) begin
                        flush_pend <= 1'b0;
                        idx        <= '0;
                        state      <= ST_FLUSH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itag_seq_ctl.sv
// tb/tb_itag_seq_ctl.sv - directed self-checking bench for itag_seq_ctl with a behavioural tag array
module tb_itag_seq_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        flush_done;
    logic        pwrdn_req = 1'b0;
    logic        fill_req = 1'b0;
    logic [8:0]  fill_addr = '0;
    logic [17:0] fill_tag = '0;
    logic        fill_gnt;
    logic        lk_req = 1'b0;
    logic [8:0]  lk_addr = '0;
    logic [17:0] lk_tag = '0;
    logic        lk_gnt;
    logic        lk_rsp_vld;
    logic        lk_hit;
    logic [8:0]  tag_addr;
    logic [17:0] tag_in;
    logic        tag_vld;
    logic        tag_we;
    logic        tag_pwrdn;
    logic        itag_hit;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    itag_seq_ctl #(.IDX_W(9), .TAG_W(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .pwrdn_req  (pwrdn_req),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_tag   (fill_tag),
        .fill_gnt   (fill_gnt),
        .lk_req     (lk_req),
        .lk_addr    (lk_addr),
        .lk_tag     (lk_tag),
        .lk_gnt     (lk_gnt),
        .lk_rsp_vld (lk_rsp_vld),
        .lk_hit     (lk_hit),
        .tag_addr   (tag_addr),
        .tag_in     (tag_in),
        .tag_vld    (tag_vld),
        .tag_we     (tag_we),
        .tag_pwrdn  (tag_pwrdn),
        .itag_hit   (itag_hit)
    );

    // Tag array model: inputs registered, write lands before the next access reads.
    logic [17:0] m_tag [512];
    logic        m_vld [512] = '{default: 1'b1};
    logic [8:0]  a_q = '0;
    logic [17:0] t_q = '0;
    logic        we_q = 1'b0;

    always @(posedge clk) begin
        a_q  <= tag_addr;
        t_q  <= tag_in;
        we_q <= (tag_we === 1'b1);
        if (tag_we === 1'b1) begin
            m_tag[tag_addr] <= tag_in;
            m_vld[tag_addr] <= tag_vld;
        end
    end

    assign itag_hit = !we_q && m_vld[a_q] && (m_tag[a_q] === t_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes, away from the edge.
    task automatic settle();
        #2;
    endtask

    initial begin
        // ---- 1: reset and full flush walk
        cyc();
        reset = 1'b0;
        settle();
        chk("rst_busy", {31'd0, flush_busy}, 32'd1);
        chk("rst_done", {31'd0, flush_done}, 32'd0);
        chk("rst_rsp", {31'd0, lk_rsp_vld}, 32'd0);
        chk("rst_pwrdn", {31'd0, tag_pwrdn}, 32'd0);
        chk("rst_gnt", {30'd0, fill_gnt, lk_gnt}, 32'd0);
        lk_req = 1'b1;
        for (int i = 0; i < 512; i++) begin
            settle();
            chk("walk1", {18'd0, flush_busy, flush_done, tag_we, tag_vld, lk_gnt, tag_addr},
                {18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'(i)});
            cyc();
        end
        lk_req = 1'b0;
        settle();
        chk("walk1_done", {30'd0, flush_busy, flush_done}, 32'h1);
        lk_req = 1'b1; lk_addr = 9'd7; lk_tag = 18'h00123;
        settle();
        chk("lk_after_flush_gnt", {31'd0, lk_gnt}, 32'd1);
        cyc();
        lk_req = 1'b0;
        settle();
        chk("lk_after_flush_rsp", {30'd0, lk_rsp_vld, lk_hit}, 32'h2);
        chk("done_one_cycle", {31'd0, flush_done}, 32'd0);

        // ---- 2: fill then lookups, back-to-back
        cyc();
        fill_req = 1'b1; fill_addr = 9'h05; fill_tag = 18'h2A5A5;
        settle();
        chk("fill_gnt", {31'd0, fill_gnt}, 32'd1);
        chk("fill_port", {tag_we, tag_vld, 3'd0, tag_addr, tag_in}, {1'b1, 1'b1, 3'd0, 9'h05, 18'h2A5A5});
        cyc();
        fill_req = 1'b0;
        lk_req = 1'b1; lk_addr = 9'h05; lk_tag = 18'h2A5A5;
        settle();
        chk("lk_gnt_a", {29'd0, lk_gnt, fill_gnt, tag_we}, 32'h4);
        cyc();
        lk_tag = 18'h2A5A4;
        settle();
        chk("lk_rsp_hit", {30'd0, lk_rsp_vld, lk_hit}, 32'h3);
        chk("lk_gnt_b2b", {31'd0, lk_gnt}, 32'd1);
        cyc();
        lk_req = 1'b0;
        settle();
        chk("lk_rsp_miss", {30'd0, lk_rsp_vld, lk_hit}, 32'h2);
        chk("hold_port", {tag_we, 4'd0, tag_addr, tag_in}, {1'b0, 4'd0, 9'h05, 18'h2A5A4});

        // ---- 3: fill and lookup together
        cyc();
        fill_req = 1'b1; fill_addr = 9'h09; fill_tag = 18'h00011;
        lk_req = 1'b1; lk_addr = 9'h09; lk_tag = 18'h00011;
        settle();
        chk("arb_fill_wins", {30'd0, fill_gnt, lk_gnt}, 32'h2);
        cyc();
        fill_req = 1'b0;
        settle();
        chk("arb_lk_next", {30'd0, fill_gnt, lk_gnt}, 32'h1);
        cyc();
        lk_req = 1'b0;
        settle();
        chk("arb_lk_rsp", {30'd0, lk_rsp_vld, lk_hit}, 32'h3);

        // ---- 4: flush restarted mid-walk
        cyc();
        flush_req = 1'b1;
        lk_req = 1'b1;
        settle();
        chk("idle_flush_nognt", {29'd0, fill_gnt, lk_gnt, tag_we}, 32'h0);
        cyc();
        flush_req = 1'b0;
        lk_req = 1'b0;
        for (int i = 0; i < 300; i++) cyc();
        settle();
        chk("walk2_at300", {23'd0, tag_addr}, 32'd300);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int i = 0; i < 512; i++) begin
            settle();
            chk("walk2", {20'd0, flush_busy, flush_done, tag_we, tag_addr}, {20'd0, 1'b1, 1'b0, 1'b1, 9'(i)});
            cyc();
        end
        settle();
        chk("walk2_done", {30'd0, flush_busy, flush_done}, 32'h1);
        lk_req = 1'b1; lk_addr = 9'h05; lk_tag = 18'h2A5A5;
        cyc();
        lk_req = 1'b0;
        settle();
        chk("walk2_invalidated", {30'd0, lk_rsp_vld, lk_hit}, 32'h2);

        // ---- 5: power down and wake by lookup
        cyc();
        pwrdn_req = 1'b1;
        settle();
        chk("pd_idle", {31'd0, tag_pwrdn}, 32'd0);
        cyc();
        settle();
        chk("pd_sleep", {31'd0, tag_pwrdn}, 32'd1);
        cyc();
        lk_req = 1'b1; lk_addr = 9'h09; lk_tag = 18'h00011;
        settle();
        chk("pd_sleep_nognt", {30'd0, tag_pwrdn, lk_gnt}, 32'h2);
        cyc();
        settle();
        chk("pd_wake", {29'd0, tag_pwrdn, lk_gnt, tag_we}, 32'h0);
        cyc();
        settle();
        chk("pd_after_wake_gnt", {30'd0, tag_pwrdn, lk_gnt}, 32'h1);
        cyc();
        lk_req = 1'b0;
        settle();
        chk("pd_lk_rsp", {30'd0, lk_rsp_vld, lk_hit}, 32'h2);

        // ---- 6: flush during sleep, then reset mid-lookup
        cyc();
        settle();
        chk("sleep2", {31'd0, tag_pwrdn}, 32'd1);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        pwrdn_req = 1'b0;
        settle();
        chk("sleep_flush_wake", {29'd0, tag_pwrdn, flush_busy, lk_gnt}, 32'h0);
        cyc();
        settle();
        chk("sleep_flush_start", {21'd0, flush_busy, tag_we, tag_addr}, {21'd0, 1'b1, 1'b1, 9'd0});
        for (int k = 0; k < 600 && flush_busy === 1'b1; k++) cyc();
        settle();
        chk("walk3_done", {30'd0, flush_busy, flush_done}, 32'h1);
        lk_req = 1'b1; lk_addr = 9'h33; lk_tag = 18'h00001;
        settle();
        chk("rst_lk_gnt", {31'd0, lk_gnt}, 32'd1);
        cyc();
        reset = 1'b1;
        settle();
        chk("rst_lk_rsp_pre", {31'd0, lk_rsp_vld}, 32'd1);
        cyc();
        reset = 1'b0;
        lk_req = 1'b0;
        settle();
        chk("rst_mid_lk", {20'd0, lk_rsp_vld, flush_busy, tag_we, tag_addr}, {20'd0, 1'b0, 1'b1, 1'b1, 9'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
